// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: PC register, single outstanding memory
// request, and a small instruction/PC FIFO drained by a valid/ready consumer.
module fetch_queue_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int QUEUE_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int PC_STEP = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Branch,
    input  logic              Zero,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] Target,
    output logic              Mem_Req,
    output logic [ADDR_W-1:0] Mem_Addr,
    input  logic              Mem_Ack,
    input  logic [DATA_W-1:0] Mem_Data,
    output logic              Inst_Valid,
    input  logic              Inst_Ready,
    output logic [DATA_W-1:0] Inst,
    output logic [ADDR_W-1:0] Inst_PC,
    output logic [ADDR_W-1:0] Fetch_PC
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] fifo_data_q [QUEUE_DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q [QUEUE_DEPTH];

    logic redirect;
    logic push;
    logic pop;

    assign redirect = Jump | (Branch & Zero);
    assign Inst_Valid = (count_q != '0);
    assign pop = Inst_Valid & Inst_Ready;

    assign Mem_Req = (state_q == S_REQ);
    assign Mem_Addr = Mem_Req ? pc_q : '0;
    assign Fetch_PC = pc_q;
    assign Inst = Inst_Valid ? fifo_data_q[rd_ptr_q] : '0;
    assign Inst_PC = Inst_Valid ? fifo_pc_q[rd_ptr_q] : '0;

    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        push = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    pc_d = Target;
                end else if (count_q < DEPTH) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect) begin
                    pc_d = Target;
                    state_d = S_DROP;
                end else begin
                    pc_d = pc_q + STEP;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d = Target;
                    state_d = Mem_Ack ? S_IDLE : S_DROP;
                end else if (Mem_Ack) begin
                    push = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    pc_d = Target;
                end
                if (Mem_Ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A redirect flushes the queue outright, overriding push and pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d = count_q;
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10: count_d = count_q + CNT_W'(1);
                2'b01: count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            pc_q <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q <= count_d;
        end
    end

    // The PC register has already stepped past the word being returned.
    always_ff @(posedge Clock) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= Mem_Data;
            fifo_pc_q[wr_ptr_q] <= pc_q - STEP;
        end
    end

endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised instruction-fetch front end of the single-cycle/multi-cycle CPU. It holds the program counter, issues one outstanding word request at a time to instruction memory, and buffers returned instructions with their PCs in a QUEUE_DEPTH-entry FIFO. A valid/ready handshake drains the FIFO toward decode. Jump, or Branch qualified by Zero, redirects the PC, flushes the FIFO and discards any in-flight response.

## Interface
- ADDR_W, 32, PC / memory address width
- DATA_W, 32, instruction width
- QUEUE_DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 0, PC value loaded by reset
- PC_STEP, 4, sequential PC increment

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-low reset (asserted when 0)
- Branch  in  1  branch instruction resolved this cycle
- Zero  in  1  ALU zero flag; qualifies Branch
- Jump  in  1  unconditional jump resolved this cycle
- Target  in  ADDR_W  redirect target PC
- Mem_Req  out  1  one-cycle request strobe
- Mem_Addr  out  ADDR_W  request address, valid with Mem_Req
- Mem_Ack  in  1  one-cycle response strobe
- Mem_Data  in  DATA_W  response word, valid with Mem_Ack
- Inst_Valid  out  1  FIFO head valid
- Inst_Ready  in  1  consumer accepts head
- Inst  out  DATA_W  head instruction
- Inst_PC  out  ADDR_W  head PC
- Fetch_PC  out  ADDR_W  current PC register (debug)

## Operation
- Redirect = Jump | (Branch & Zero). Highest priority of all events in a cycle.
- FSM states:
  - IDLE: no request outstanding.
    - Redirect: PC←Target, stay IDLE.
    - Else if count < QUEUE_DEPTH: go to REQ.
  - REQ: Mem_Req=1, Mem_Addr=PC; always leaves after one cycle.
    - No redirect: PC←PC+PC_STEP, go to WAIT.
    - Redirect: PC←Target, go to DROP.
  - WAIT:
    - Redirect: PC←Target, go to DROP. A Mem_Ack in the same cycle is discarded and the FSM goes to IDLE instead.
    - Mem_Ack: push {PC−PC_STEP, Mem_Data}, go to IDLE.
  - DROP:
    - Mem_Ack: discard the data, go to IDLE.
    - Redirect: PC←Target, stay DROP unless Mem_Ack is also present.
- Mem_Ack is ignored in IDLE and REQ (protocol violation).
- Only one request is ever outstanding. The space check happens only in IDLE, so a push never overflows.
- FIFO:
  - Read and write pointers are log2(QUEUE_DEPTH) bits and wrap modulo depth.
  - count ranges 0..QUEUE_DEPTH.
  - Pop = Inst_Valid & Inst_Ready. Simultaneous push and pop leaves count unchanged.
  - Redirect clears count and both pointers in the same edge, overriding any push or pop.
- Inst_Valid = (count≠0).
- Inst and Inst_PC show the head entry while Inst_Valid=1 and are forced to 0 otherwise.
- PC arithmetic is modulo 2^ADDR_W. Wrap from the top address to 0 is legal.
- Reset (Reset=0 at an edge):
  - Registers: PC←RESET_PC, state IDLE, count 0, pointers 0.
  - Outputs: Mem_Req 0, Mem_Addr 0, Inst_Valid 0, Inst 0, Inst_PC 0, Fetch_PC RESET_PC.
  - Reset mid-request abandons the transaction. Instruction memory shares this reset and must drop its pending response.

## Timing
- Mem_Req and Mem_Addr are registered state outputs.
- Mem_Ack arrives ≥1 cycle after the REQ cycle; any latency is allowed.
- After reset release (cycle 0 = IDLE):
  - Cycle 1: REQ with Mem_Addr=RESET_PC.
  - Cycle 2 at earliest: Mem_Ack.
  - Cycle 3: Inst_Valid=1.
- Peak throughput with 1-cycle memory is one instruction per 3 cycles (IDLE→REQ→WAIT).
- Redirect sampled at edge N:
  - Fetch_PC = Target from cycle N+1.
  - If no request was outstanding, the first Mem_Req with Mem_Addr=Target comes at N+2.
- Pop takes effect at the edge. The next head is visible in the following cycle.
- With a full FIFO and Inst_Ready=0, the FSM holds IDLE and Mem_Req stays 0.

## Test plan
- Reset release, 1-cycle memory returning Mem_Data=addr^32'hA5A5_0000, Inst_Ready=1 → Inst/Inst_PC pairs at PC 0,4,8,12 in order, each with the matching data.
- Inst_Ready=0, QUEUE_DEPTH=4 → exactly 4 requests (0,4,8,12), then Mem_Req stays 0 and Fetch_PC=16. Raising Inst_Ready drains 0,4,8,12 and fetching resumes at 16.
- Jump=1, Target=0x100 while in WAIT, ack 3 cycles later → Inst_Valid drops next cycle, the late data is never output, and the next Mem_Addr=0x100.
- Branch=1, Zero=0 → no redirect and no flush. Branch=1, Zero=1, Target=0x40 → flush, and the first valid Inst_PC is 0x40.
- Redirect coincident with Mem_Ack in WAIT, and with pop in the same cycle → FIFO empty, FSM IDLE, PC=Target.
- Reset=0 asserted in WAIT, then a stale ack → all outputs at reset values, the stale ack is ignored, and fetch restarts at RESET_PC. PC=0xFFFF_FFFC with an ack → next Mem_Addr=0.
